// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for a 16-point complex FFT frame.
// A frame is captured into a pending bank, moved to a work bank when the FSM is idle,
// scanned two points per cycle for the largest re^2 + im^2, and the winning index is
// reported with a one-cycle done pulse.
module fft_peak_analyzer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic          done,
    output logic [3:0]    freq,
    output logic          overrun
);

    localparam int MW = 2 * DW;

    typedef enum logic [1:0] {StIdle, StScan, StReport} state_t;

    state_t          state;
    logic [MW-1:0]   din  [16];
    logic [MW-1:0]   pend [16];
    logic [MW-1:0]   work [16];
    logic            pend_flag;
    logic [2:0]      cnt;
    logic [MW-1:0]   max_mag;
    logic [3:0]      max_idx;

    logic            consume;
    logic [MW-1:0]   mag0;
    logic [MW-1:0]   mag1;
    logic [MW-1:0]   pair_mag;
    logic [3:0]      pair_idx;
    logic            take;

    // re^2 + im^2; the sum of two squares of DW-bit values never exceeds 2^(MW-1),
    // so an unsigned MW-bit result is exact.
    function automatic logic [MW-1:0] mag_of(input logic [MW-1:0] pt);
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [MW-1:0]        rr;
        logic [MW-1:0]        ii;
        re = pt[MW-1:DW];
        im = pt[DW-1:0];
        rr = re * re;
        ii = im * im;
        return rr + ii;
    endfunction

    // Gather the flat input ports into an indexable bank.
    always_comb begin
        din[0]  = fft_d0;  din[1]  = fft_d1;  din[2]  = fft_d2;  din[3]  = fft_d3;
        din[4]  = fft_d4;  din[5]  = fft_d5;  din[6]  = fft_d6;  din[7]  = fft_d7;
        din[8]  = fft_d8;  din[9]  = fft_d9;  din[10] = fft_d10; din[11] = fft_d11;
        din[12] = fft_d12; din[13] = fft_d13; din[14] = fft_d14; din[15] = fft_d15;
    end

    // Pair compare and running-maximum decision for the current scan step.
    always_comb begin
        consume  = (state == StIdle) && pend_flag;
        mag0     = mag_of(work[{cnt, 1'b0}]);
        mag1     = mag_of(work[{cnt, 1'b1}]);
        // Strictly greater: the even (lower) index keeps a tie.
        if (mag1 > mag0) begin
            pair_mag = mag1;
            pair_idx = {cnt, 1'b1};
        end else begin
            pair_mag = mag0;
            pair_idx = {cnt, 1'b0};
        end
        // First pair seeds the maximum so a previous frame never leaks in.
        take = (cnt == 3'd0) || (pair_mag > max_mag);
    end

    // Capture banks, control FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            done      <= 1'b0;
            freq      <= 4'd0;
            overrun   <= 1'b0;
            pend_flag <= 1'b0;
            cnt       <= 3'd0;
            max_mag   <= '0;
            max_idx   <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                pend[i] <= '0;
                work[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;

            if (fft_valid) begin
                for (int i = 0; i < 16; i++) pend[i] <= din[i];
                pend_flag <= 1'b1;
                // Losing a frame only when the pending one is not being moved out now.
                overrun   <= pend_flag && !consume;
            end else if (consume) begin
                pend_flag <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (pend_flag) begin
                        for (int i = 0; i < 16; i++) work[i] <= pend[i];
                        cnt   <= 3'd0;
                        state <= StScan;
                    end
                end
                StScan: begin
                    if (take) begin
                        max_mag <= pair_mag;
                        max_idx <= pair_idx;
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= StReport;
                end
                StReport: begin
                    freq  <= max_idx;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
